// File: rtl/csm51a_proj2_pkg.sv
// Shared types, segment patterns and polarity helper for the BCD to seven-segment decoder.
package csm51a_proj2_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [SEG_W-1:0] seg_t;

  // Segment bundle in {a,b,c,d,e,f,g} order, MSB = a.
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_s;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_BLANK = 7'b0000000;

  // Converts a lit-high pattern to the pin polarity of the attached display.
  function automatic seg_t apply_polarity(input seg_t lit, input logic active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/csm51a_proj2_if.sv
// Decoder bus: BCD code in, lit-high segment pattern out.
interface csm51a_proj2_if;
  import csm51a_proj2_pkg::*;

  bcd_t bcd;
  seg_t seg;

  modport master (output bcd, input seg);
  modport slave  (input bcd, output seg);
endinterface

// File: rtl/csm51a_proj2_bcd_to_seg.sv
// Combinational BCD to lit-high seven-segment pattern; codes 10-15 blank the digit.
module bcd_to_seg
  import csm51a_proj2_pkg::*;
(
  csm51a_proj2_if.slave dec
);

  always_comb begin
    dec.seg = SEG_BLANK;
    case (dec.bcd)
      4'd0:    dec.seg = SEG_0;
      4'd1:    dec.seg = SEG_1;
      4'd2:    dec.seg = SEG_2;
      4'd3:    dec.seg = SEG_3;
      4'd4:    dec.seg = SEG_4;
      4'd5:    dec.seg = SEG_5;
      4'd6:    dec.seg = SEG_6;
      4'd7:    dec.seg = SEG_7;
      4'd8:    dec.seg = SEG_8;
      4'd9:    dec.seg = SEG_9;
      default: dec.seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/csm51a_proj2.sv
// Single-digit BCD to seven-segment driver with registered, polarity-selectable outputs.
module csm51a_proj2
  import csm51a_proj2_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic x3,
  input  logic x2,
  input  logic x1,
  input  logic x0,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g
);

  localparam seg_t SEG_RESET = apply_polarity(SEG_BLANK, ACTIVE_LOW);

  csm51a_proj2_if dec_if ();

  assign dec_if.bcd = {x3, x2, x1, x0};

  bcd_to_seg u_dec (
    .dec (dec_if.slave)
  );

  seg_s seg_d;
  seg_s seg_q;

  always_comb begin
    seg_d = seg_s'(apply_polarity(dec_if.seg, ACTIVE_LOW));
  end

  // Only the register reaches the pins, so outputs cannot glitch between edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seg_q <= seg_s'(SEG_RESET);
    else     seg_q <= seg_d;
  end

  assign a = seg_q.a;
  assign b = seg_q.b;
  assign c = seg_q.c;
  assign d = seg_q.d;
  assign e = seg_q.e;
  assign f = seg_q.f;
  assign g = seg_q.g;

endmodule

// File: tb/tb_csm51a_proj2.sv
// Scoreboard bench for csm51a_proj2: active-high and active-low instances share one input bus.
module tb_csm51a_proj2;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_n;
  logic [6:0] exp_q[$];
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  csm51a_proj2_if tb_if ();

  csm51a_proj2 #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst(rst),
    .x3(tb_if.bcd[3]), .x2(tb_if.bcd[2]), .x1(tb_if.bcd[1]), .x0(tb_if.bcd[0]),
    .a(tb_if.seg[6]), .b(tb_if.seg[5]), .c(tb_if.seg[4]), .d(tb_if.seg[3]),
    .e(tb_if.seg[2]), .f(tb_if.seg[1]), .g(tb_if.seg[0])
  );

  csm51a_proj2 #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst(rst),
    .x3(tb_if.bcd[3]), .x2(tb_if.bcd[2]), .x1(tb_if.bcd[1]), .x0(tb_if.bcd[0]),
    .a(seg_n[6]), .b(seg_n[5]), .c(seg_n[4]), .d(seg_n[3]),
    .e(seg_n[2]), .f(seg_n[1]), .g(seg_n[0])
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] code);
    case (code)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic drive(input logic [3:0] code);
    tb_if.bcd = code;
    exp_q.push_back(ref_seg(code));
  endtask

  task automatic test_reset();
    logic [6:0] ex;
    rst = 1'b1;
    tb_if.bcd = 4'd0;
    repeat (2) @(negedge clk);
    total += 2;
    if (tb_if.seg !== 7'b0000000) $display("FAIL reset_hi got=%b exp=0000000", tb_if.seg); else passed++;
    if (seg_n !== 7'b1111111) $display("FAIL reset_lo got=%b exp=1111111", seg_n); else passed++;
    rst = 1'b0;
    drive(4'd8);
    @(negedge clk);
    ex = exp_q.pop_front();
    total++;
    if (tb_if.seg !== ex) $display("FAIL pre_reset_8 got=%b exp=%b", tb_if.seg, ex); else passed++;
    // Mid-cycle reset must blank without waiting for a clock edge.
    #2 rst = 1'b1;
    #1;
    total += 2;
    if (tb_if.seg !== 7'b0000000) $display("FAIL async_reset_hi got=%b exp=0000000", tb_if.seg); else passed++;
    if (seg_n !== 7'b1111111) $display("FAIL async_reset_lo got=%b exp=1111111", seg_n); else passed++;
    @(posedge clk);
    #1;
    total++;
    if (tb_if.seg !== 7'b0000000) $display("FAIL reset_held got=%b exp=0000000", tb_if.seg); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total += 2;
    if (tb_if.seg !== 7'b1111111) $display("FAIL post_reset_hi got=%b exp=1111111", tb_if.seg); else passed++;
    if (seg_n !== 7'b0000000) $display("FAIL post_reset_lo got=%b exp=0000000", seg_n); else passed++;
  endtask

  task automatic test_sweep();
    logic [6:0] ex;
    drive(4'd0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      ex = exp_q.pop_front();
      total += 2;
      if (tb_if.seg !== ex) $display("FAIL sweep_%0d got=%b exp=%b", i - 1, tb_if.seg, ex); else passed++;
      if (seg_n !== ~ex) $display("FAIL sweep_lo_%0d got=%b exp=%b", i - 1, seg_n, ~ex); else passed++;
      if (i < 10) drive(4'(i));
    end
  endtask

  task automatic test_invalid();
    logic [6:0] ex;
    logic [3:0] codes [7] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd5};
    drive(codes[0]);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      ex = exp_q.pop_front();
      total += 2;
      if (tb_if.seg !== ex) $display("FAIL invalid_%0d got=%b exp=%b", codes[i-1], tb_if.seg, ex); else passed++;
      if (seg_n !== ~ex) $display("FAIL invalid_lo_%0d got=%b exp=%b", codes[i-1], seg_n, ~ex); else passed++;
      if (i < 7) drive(codes[i]);
    end
  endtask

  task automatic test_glitch();
    logic [6:0] ex;
    drive(4'd1);
    @(negedge clk);
    ex = exp_q.pop_front();
    total++;
    if (tb_if.seg !== ex) $display("FAIL glitch_start got=%b exp=%b", tb_if.seg, ex); else passed++;
    @(posedge clk);
    #1 tb_if.bcd = 4'd3;
    #1;
    total++;
    if (tb_if.seg !== 7'b0110000) $display("FAIL glitch_hold3 got=%b exp=0110000", tb_if.seg); else passed++;
    tb_if.bcd = 4'd4;
    #1;
    total++;
    if (tb_if.seg !== 7'b0110000) $display("FAIL glitch_hold4 got=%b exp=0110000", tb_if.seg); else passed++;
    drive(4'd3);
    @(negedge clk);
    total++;
    if (tb_if.seg !== 7'b0110000) $display("FAIL glitch_hold_neg got=%b exp=0110000", tb_if.seg); else passed++;
    @(negedge clk);
    ex = exp_q.pop_front();
    total++;
    if (tb_if.seg !== ex) $display("FAIL glitch_after got=%b exp=%b", tb_if.seg, ex); else passed++;
  endtask

  task automatic test_polarity();
    drive(4'd0);
    @(negedge clk);
    void'(exp_q.pop_front());
    total++;
    if (seg_n !== 7'b0000001) $display("FAIL pol_0 got=%b exp=0000001", seg_n); else passed++;
    drive(4'd8);
    @(negedge clk);
    void'(exp_q.pop_front());
    total++;
    if (seg_n !== 7'b0000000) $display("FAIL pol_8 got=%b exp=0000000", seg_n); else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (seg_n !== 7'b1111111) $display("FAIL pol_rst got=%b exp=1111111", seg_n); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    logic [6:0] ex;
    logic [3:0] codes [3] = '{4'd9, 4'd0, 4'd1};
    drive(codes[0]);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      ex = exp_q.pop_front();
      total++;
      if (tb_if.seg !== ex) $display("FAIL wrap_%0d got=%b exp=%b", codes[i-1], tb_if.seg, ex); else passed++;
      if (i < 3) drive(codes[i]);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_invalid();
    test_glitch();
    test_polarity();
    test_wrap();
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/csm51a_proj2.md
Name: csm51a_proj2

Overview:
- BCD-to-seven-segment decoder for a single digit.
- Takes a 4-bit BCD code on x3..x0 (x3 = MSB) and drives the seven segment lines a..g.
- Outputs are registered: one clock of latency, with a defined blank state under reset.
- Sits between the digit source (counter/switches) and one display digit.

Parameters:
- ACTIVE_LOW, 0, 0 means a lit segment is driven 1; 1 means all seven outputs are inverted (lit = 0), including the reset/blank value.

Ports:
- clk  input  1  system clock; all outputs update on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- x3  input  1  BCD bit 3 (MSB).
- x2  input  1  BCD bit 2.
- x1  input  1  BCD bit 1.
- x0  input  1  BCD bit 0 (LSB).
- a  output  1  segment a (top).
- b  output  1  segment b (upper right).
- c  output  1  segment c (lower right).
- d  output  1  segment d (bottom).
- e  output  1  segment e (lower left).
- f  output  1  segment f (upper left).
- g  output  1  segment g (middle).

Behaviour:
- Clocking and reset:
  - Interface: one clock (clk); reset rst is asynchronous and active-high.
  - While rst = 1, all segments are immediately blank: pattern 0000000 at ACTIVE_LOW = 0, 1111111 at ACTIVE_LOW = 1.
  - Deasserting rst takes effect at the next clk rising edge.
  - Reset mid-operation blanks at once, independent of clk.
- Latency and glitch rules:
  - Inputs are sampled at the clk rising edge. The decoded pattern appears on a..g after that edge and holds until the next edge: latency 1 cycle.
  - No combinational path from inputs to outputs.
  - Outputs are glitch-free between edges.
- Decode table, listed as {a,b,c,d,e,f,g}, lit = 1 before polarity inversion:
  - 0 -> 1111110
  - 1 -> 0110000
  - 2 -> 1101101
  - 3 -> 1111001
  - 4 -> 0110011
  - 5 -> 1011011
  - 6 -> 1011111 (6 has the top tail)
  - 7 -> 1110000 (7 has no f)
  - 8 -> 1111111
  - 9 -> 1111011 (9 has the bottom tail)
- Invalid codes 10-15 (x3 = 1 with x2 or x1 set) give blank, 0000000 before inversion.
- Boundaries:
  - Input changes between edges have no effect until the next edge.
  - Back-to-back code changes on consecutive cycles each appear exactly one cycle later.
  - 9 -> 0 wrap needs no special handling.
- Polarity: ACTIVE_LOW inversion is applied after decode, uniformly to all seven outputs.

Decomposition:
- Package csm51a_proj2_pkg:
  - 7-bit segment-pattern constants SEG_0..SEG_9 and SEG_BLANK, in {a,b,c,d,e,f,g} order, lit = 1.
  - A function for the polarity inversion.
- One combinational sub-module, bcd_to_seg: 4-bit BCD in, 7-bit lit-high pattern out, implementing the table plus the invalid -> blank rule.
- The top level holds the input concatenation, the output register with async reset, the polarity inversion, and the fan-out to a..g.

Test Plan:
- Reset: assert rst mid-cycle while x = 8 with outputs showing 1111111 -> outputs go to 0000000 immediately without a clk edge, stay there while rst is held, and show 1111111 one edge after release (ACTIVE_LOW = 0).
- Sweep: drive x = 0..9 (x3..x0 = code), one new value per cycle -> each cycle's {a..g} equals the table value of the code applied one edge earlier, e.g. 2 -> 1101101, 7 -> 1110000, 9 -> 1111011.
- Invalid codes: drive 10, 11, 12, 13, 14, 15 -> 0000000 each cycle; then 5 -> 1011011 on the following edge.
- Latency and glitch-freedom: change x from 1 to 3 just after an edge and toggle it 3 -> 4 -> 3 before the next edge -> outputs hold 0110000 until the edge, then show 1111001.
- Polarity: ACTIVE_LOW = 1, apply 0 -> 0000001; apply 8 -> 0000000; apply rst -> 1111111.
- Wrap: apply 9, then 0, then 1 -> 1111011, 1111110, 0110000 on successive edges.
